bnn_seq_ctrl: RTL and testbench

BNN_SEQ_CTRL -- requirements
Module: bnn_seq_ctrl

---
 rtl/bnn_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: sequencing controller for a bit-serial binarised neural network
// classifier core. Accepts one sample, holds it for the core, releases the core
// from reset for a fixed number of clock edges, then samples and decodes the
// core's class index and holds the result until the consumer takes it.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous active-high reset
//   in_data    : sample to classify (B*N bits)
//   in_valid   : in_data valid
//   in_ready   : controller idle, sample will be accepted on the next edge
//   core_data  : sample held for the classifier core
//   core_rst   : registered reset/start to the classifier core
//   core_klass : raw class index from the core
//   out_label  : decoded label, C-1-core_klass (wraps modulo 2^$clog2(C))
//   out_err    : raw class index was above C-1
//   out_valid  : out_label / out_err valid
//   out_ready  : consumer accepts the result
//   done_cnt   : results delivered since reset (wraps)
//
// state | meaning
// IDLE  | waiting for a sample, in_ready=1, core held in reset
// START | sample latched, core still in reset for one more cycle
// RUN   | core running, cnt counts 0..N+M, result sampled at cnt==N+M
// HOLD  | result presented, waiting for out_ready

module bnn_seq_ctrl #(
  parameter int N = 16,
  parameter int M = 40,
  parameter int B = 4,
  parameter int C = 10,
  localparam int KW = $clog2(C),
  localparam int CW = $clog2(N + M + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [B*N-1:0]    in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [B*N-1:0]    core_data,
  output logic              core_rst,
  input  logic [KW-1:0]     core_klass,
  output logic [KW-1:0]     out_label,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       done_cnt
);

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(N + M);
  localparam logic [KW-1:0] K_MAX    = KW'(C - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [B*N-1:0]  data_q, data_nxt;
  logic [KW-1:0]   label_nxt;
  logic            err_nxt;
  logic            valid_nxt;
  logic            core_rst_nxt;
  logic [15:0]     done_nxt;

  assign in_ready  = (state == IDLE);
  assign core_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      out_label <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      done_cnt  <= '0;
      core_rst  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      data_q    <= data_nxt;
      out_label <= label_nxt;
      out_err   <= err_nxt;
      out_valid <= valid_nxt;
      done_cnt  <= done_nxt;
      core_rst  <= core_rst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    label_nxt = out_label;
    err_nxt   = out_err;
    valid_nxt = out_valid;
    done_nxt  = done_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in_data;
          state_nxt = START;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          // subtraction wraps at KW bits so out-of-range indices still decode
          label_nxt = K_MAX - core_klass;
          err_nxt   = (core_klass > K_MAX);
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          done_nxt  = done_cnt + 16'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // core_rst follows the state it will be in, so it is registered yet aligned
    core_rst_nxt = (state_nxt == IDLE) || (state_nxt == START);
  end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Testbench for bnn_seq_ctrl: behavioural core model plus a scoreboard.
// The driver pushes the expected decoded result at each accept; an independent
// monitor pops and compares whenever a result appears on out_valid.

module tb_bnn_seq_ctrl;
  localparam int N   = 16;
  localparam int M   = 40;
  localparam int B   = 4;
  localparam int C   = 10;
  localparam int KW  = $clog2(C);
  localparam int W   = B * N;
  localparam int LAT = N + M + 2;
  localparam int GAP = N + M + 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   core_data;
  logic           core_rst;
  logic [KW-1:0]  core_klass;
  logic [KW-1:0]  out_label;
  logic           out_err;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [15:0]    done_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [KW-1:0] label;
    logic          err;
    int            acc;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0]  exp_core = '0;
  int            exp_done = 0;
  logic [KW-1:0] cur_klass = '0;
  int            core_edges = 0;

  bnn_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .core_data(core_data), .core_rst(core_rst),
    .core_klass(core_klass), .out_label(out_label), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // core model: all-ones until it has seen N+M edges out of reset
  always @(posedge clk) core_edges <= core_rst ? 0 : core_edges + 1;
  assign core_klass = (core_edges >= N + M) ? cur_klass : '1;

  // a result is delivered on every edge where out_valid and out_ready are both high
  always @(posedge clk or posedge rst)
    if (rst) exp_done <= 0;
    else if (out_valid && out_ready) exp_done <= (exp_done + 1) % 65536;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor
  logic          prev_valid = 1'b0;
  logic [KW-1:0] held_label;
  logic          held_err;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      chk("core_data", core_data, exp_core);
      chk("done_cnt", done_cnt, 64'(exp_done));
      chk("ready_valid_excl", in_ready && out_valid, 0);
      if (out_valid) begin
        if (!prev_valid) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got out_valid=1 label=%0d expected no result", out_label);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("label", out_label, e.label);
            chk("err", out_err, e.err);
            chk("latency", cyc - e.acc, LAT);
          end
          held_label = out_label;
          held_err   = out_err;
        end else begin
          chk("hold_label", out_label, held_label);
          chk("hold_err", out_err, held_err);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] d, input int k, input bit keep_valid);
    int t;
    int md;
    int lab;
    exp_t e;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    md  = 1 << KW;
    lab = ((C - 1 - k) % md + md) % md;
    cur_klass = lab[KW-1:0];
    cur_klass = KW'(k);
    exp_core  = d;
    e.label = lab[KW-1:0];
    e.err   = (k > C - 1);
    e.acc   = cyc;
    sb.push_back(e);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("result_timeout", out_valid, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_core = '0;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_data", core_data, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_label", out_label, 0);
    chk("rst_err", out_err, 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [W-1:0] v [5];
    int prev_acc;
    int k;
    int dl;

    repeat (3) @(negedge clk);
    chk("init_core_rst", core_rst, 1);
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_done_cnt", done_cnt, 0);
    chk("init_core_data", core_data, 0);

    // single sample accepted on the first edge after reset release
    in_data   = 64'h8f4d96400498fe6f;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b0;
    #1;
    chk("first_accept_ready", in_ready, 1);
    send(64'h8f4d96400498fe6f, 3, 0);
    wait_valid();
    chk("single_label", out_label, 6);
    chk("single_err", out_err, 0);
    @(negedge clk);
    chk("single_done", done_cnt, 1);
    chk("single_valid_drop", out_valid, 0);

    // back-pressure
    out_ready = 1'b0;
    send(rnd64(), 0, 0);
    wait_valid();
    repeat (20) begin
      @(negedge clk);
      chk("bp_label", out_label, 9);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_done", done_cnt, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_after", done_cnt, 2);

    // out-of-range core index
    send(rnd64(), 12, 0);
    wait_valid();
    chk("oor_err", out_err, 1);
    chk("oor_label", out_label, 13);
    @(negedge clk);

    // back-to-back with in_valid held
    do_reset();
    out_ready = 1'b1;
    v[0] = 64'h8f4d96400498fe6f;
    for (int i = 1; i < 5; i++) v[i] = rnd64();
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send(v[i], $urandom_range(0, C - 1), i < 4);
      if (i > 0) chk("b2b_gap", cyc - prev_acc, GAP);
      prev_acc = cyc;
    end
    wait_valid();
    @(negedge clk);
    chk("b2b_done", done_cnt, 5);

    // reset in the middle of RUN
    send(rnd64(), 5, 0);
    repeat (21) @(posedge clk);
    do_reset();
    repeat (80) @(negedge clk);
    chk("midrst_no_valid", out_valid, 0);
    send(rnd64(), 7, 0);
    wait_valid();
    @(negedge clk);
    chk("midrst_done", done_cnt, 1);

    // input activity during RUN must not disturb the held sample
    send(rnd64(), 2, 0);
    repeat (50) begin
      @(negedge clk);
      in_data  = rnd64();
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    wait_valid();
    @(negedge clk);

    // randomized samples with random consumer delay
    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(0, (1 << KW) - 1);
      dl = $urandom_range(0, 4);
      out_ready = 1'b0;
      send(rnd64(), k, 0);
      wait_valid();
      repeat (dl) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
